// File: rtl/cordic_arbiter_pkg.sv
// Shared definitions for the CORDIC engine arbiter: FSM state encoding and
// default widths and latency of the shared rotation engine.
package cordic_arbiter_pkg;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DW         = 40;
    localparam int DEF_AW         = 32;
    localparam int DEF_CORDIC_LAT = 58;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: first set request at or above ptr, wrapping
// to the lowest set request when nothing at or above ptr is asking.
module rr_picker #(
    parameter int N_REQ = 4,
    localparam int PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [PW-1:0]    win_idx,
    output logic             req_any
);

    logic [N_REQ-1:0] ge_mask;
    logic [N_REQ-1:0] hi_req;
    logic [N_REQ-1:0] pool;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign ge_mask[gi] = (int'(ptr) <= gi);
    end

    assign hi_req  = req & ge_mask;
    assign pool    = (hi_req != '0) ? hi_req : req;
    assign req_any = |req;

    always_comb begin
        win_idx = '0;
        // Scan downward so the lowest set bit of the pool wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                win_idx = PW'(i);
            end
        end
        win_onehot = req_any ? (N_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one CORDIC rotation engine: latches the
// winner's operands, holds the engine start level, then returns tagged cos/sin.
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int CORDIC_LAT = DEF_CORDIC_LAT
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_xi,
    input  logic [N_REQ*DW-1:0] req_yi,
    input  logic [N_REQ*AW-1:0] req_angle,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       res_cos,
    output logic [DW-1:0]       res_sin,
    output logic [2:0]          res_id,
    output logic                busy,
    output logic                cord_start,
    output logic [DW-1:0]       cord_xi,
    output logic [DW-1:0]       cord_yi,
    output logic [AW-1:0]       cord_angle,
    input  logic [DW-1:0]       cord_cos,
    input  logic [DW-1:0]       cord_sin
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(CORDIC_LAT);

    arb_state_t       state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    win_idx_reg;
    logic [CW-1:0]    cnt_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [N_REQ-1:0] done_reg;
    logic [DW-1:0]    res_cos_reg;
    logic [DW-1:0]    res_sin_reg;
    logic [2:0]       res_id_reg;
    logic [DW-1:0]    cord_xi_reg;
    logic [DW-1:0]    cord_yi_reg;
    logic [AW-1:0]    cord_angle_reg;

    logic [DW-1:0] xi_slice    [N_REQ];
    logic [DW-1:0] yi_slice    [N_REQ];
    logic [AW-1:0] angle_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign xi_slice[gi]    = req_xi[gi*DW +: DW];
        assign yi_slice[gi]    = req_yi[gi*DW +: DW];
        assign angle_slice[gi] = req_angle[gi*AW +: AW];
    end

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (req),
        .ptr        (ptr_reg),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .req_any    (pick_any)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            win_idx_reg    <= '0;
            cnt_reg        <= '0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            res_cos_reg    <= '0;
            res_sin_reg    <= '0;
            res_id_reg     <= '0;
            cord_xi_reg    <= '0;
            cord_yi_reg    <= '0;
            cord_angle_reg <= '0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    // Operands are guaranteed stable through the grant cycle.
                    if (pick_any) begin
                        state_reg      <= LAUNCH;
                        gnt_reg        <= pick_onehot;
                        win_idx_reg    <= pick_idx;
                        cord_xi_reg    <= xi_slice[pick_idx];
                        cord_yi_reg    <= yi_slice[pick_idx];
                        cord_angle_reg <= angle_slice[pick_idx];
                    end
                end
                LAUNCH: begin
                    cnt_reg   <= '0;
                    ptr_reg   <= (win_idx_reg == PW'(N_REQ - 1)) ? '0 : win_idx_reg + 1'b1;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg == CW'(CORDIC_LAT - 1)) begin
                        state_reg <= CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CAPTURE: begin
                    res_cos_reg <= cord_cos;
                    res_sin_reg <= cord_sin;
                    res_id_reg  <= 3'(win_idx_reg);
                    done_reg    <= N_REQ'(1) << win_idx_reg;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Dropping start in IDLE is what resets the engine between operations.
    assign cord_start = (state_reg != IDLE);
    assign busy       = (state_reg != IDLE);
    assign gnt        = gnt_reg;
    assign done       = done_reg;
    assign res_cos    = res_cos_reg;
    assign res_sin    = res_sin_reg;
    assign res_id     = res_id_reg;
    assign cord_xi    = cord_xi_reg;
    assign cord_yi    = cord_yi_reg;
    assign cord_angle = cord_angle_reg;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter with a stub engine and a grant/done scoreboard.
module tb_cordic_arbiter;

    localparam int N   = 4;
    localparam int DW  = 40;
    localparam int AW  = 32;
    localparam int LAT = 58;

    logic            pclk = 1'b0;
    logic            preset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_xi;
    logic [N*DW-1:0] req_yi;
    logic [N*AW-1:0] req_angle;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   res_cos;
    logic [DW-1:0]   res_sin;
    logic [2:0]      res_id;
    logic            busy;
    logic            cord_start;
    logic [DW-1:0]   cord_xi;
    logic [DW-1:0]   cord_yi;
    logic [AW-1:0]   cord_angle;
    logic [DW-1:0]   cord_cos;
    logic [DW-1:0]   cord_sin;

    logic [DW-1:0] xi_v  [N];
    logic [DW-1:0] yi_v  [N];
    logic [AW-1:0] ang_v [N];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    initial forever #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    for (genvar gk = 0; gk < N; gk++) begin : g_pack
        assign req_xi[gk*DW +: DW]    = xi_v[gk];
        assign req_yi[gk*DW +: DW]    = yi_v[gk];
        assign req_angle[gk*AW +: AW] = ang_v[gk];
    end

    cordic_arbiter #(.N_REQ(N), .DW(DW), .AW(AW), .CORDIC_LAT(LAT)) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .req        (req),
        .req_xi     (req_xi),
        .req_yi     (req_yi),
        .req_angle  (req_angle),
        .gnt        (gnt),
        .done       (done),
        .res_cos    (res_cos),
        .res_sin    (res_sin),
        .res_id     (res_id),
        .busy       (busy),
        .cord_start (cord_start),
        .cord_xi    (cord_xi),
        .cord_yi    (cord_yi),
        .cord_angle (cord_angle),
        .cord_cos   (cord_cos),
        .cord_sin   (cord_sin)
    );

    // Stub engine: result appears after LAT cycles of start high.
    logic [7:0] st_cnt;
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)              st_cnt <= '0;
        else if (!cord_start)       st_cnt <= '0;
        else if (st_cnt != 8'd255)  st_cnt <= st_cnt + 8'd1;
    end
    assign cord_cos = (cord_start && st_cnt >= 8'(LAT)) ? cord_xi + 40'd1 : '0;
    assign cord_sin = (cord_start && st_cnt >= 8'(LAT)) ? {{8{cord_angle[31]}}, cord_angle} : '0;

    typedef struct {
        int            id;
        logic [DW-1:0] cos;
        logic [DW-1:0] sin;
        int            t;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: push expectation at each grant, check it at the matching done.
    always @(negedge pclk) begin
        exp_t e;
        int   gid;
        if (preset_n) begin
            if (gnt != '0) begin
                tests_run++;
                if (!$onehot(gnt)) begin
                    tests_failed++;
                    $display("FAIL sb_gnt_onehot: got %b required one-hot", gnt);
                end
                gid = 0;
                for (int k = 0; k < N; k++) if (gnt[k]) gid = k;
                e.id  = gid;
                e.cos = xi_v[gid] + 40'd1;
                e.sin = {{8{ang_v[gid][31]}}, ang_v[gid]};
                e.t   = cyc;
                sb.push_back(e);
                $display("[TB] t=%0d gnt=%b id=%0d xi=%0h angle=%0h", cyc, gnt, gid, xi_v[gid], ang_v[gid]);
            end
            if (done != '0) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected_done: got done=%b required no done", done);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] t=%0d done=%b res_id=%0d cos=%0h sin=%0h", cyc, done, res_id, res_cos, res_sin);
                    if (done !== (4'b0001 << e.id)) begin
                        tests_failed++;
                        $display("FAIL sb_done_id: got %b required %b", done, 4'b0001 << e.id);
                    end
                    tests_run++;
                    if (res_cos !== e.cos) begin
                        tests_failed++;
                        $display("FAIL sb_res_cos: got %0h required %0h", res_cos, e.cos);
                    end
                    tests_run++;
                    if (res_sin !== e.sin) begin
                        tests_failed++;
                        $display("FAIL sb_res_sin: got %0h required %0h", res_sin, e.sin);
                    end
                    tests_run++;
                    if (res_id !== 3'(e.id)) begin
                        tests_failed++;
                        $display("FAIL sb_res_id: got %0d required %0d", res_id, e.id);
                    end
                    tests_run++;
                    if (cyc - e.t !== LAT + 2) begin
                        tests_failed++;
                        $display("FAIL sb_latency: got %0d required %0d", cyc - e.t, LAT + 2);
                    end
                    tests_run++;
                    if (cord_start !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL sb_start_gap: got cord_start=%b required 0", cord_start);
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input int budget, output logic [N-1:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (gnt != '0) begin
                g = gnt;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output int t);
        d = '0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (done != '0) begin
                d = done;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        req      = '0;
        preset_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge pclk);
        tests_run++;
        if ({gnt, done, busy, cord_start} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b start=%b required all 0", gnt, done, busy, cord_start);
        end
        tests_run++;
        if ({res_cos, res_sin, res_id} !== '0) begin
            tests_failed++;
            $display("FAIL reset_res: got cos=%0h sin=%0h id=%0d required 0", res_cos, res_sin, res_id);
        end
        tests_run++;
        if ({cord_xi, cord_yi, cord_angle} !== '0) begin
            tests_failed++;
            $display("FAIL reset_oper: got xi=%0h yi=%0h angle=%0h required 0", cord_xi, cord_yi, cord_angle);
        end
        preset_n = 1'b1;
        repeat (3) @(negedge pclk);
        tests_run++;
        if (busy !== 1'b0 || gnt !== '0) begin
            tests_failed++;
            $display("FAIL idle_no_req: got busy=%b gnt=%b required 0", busy, gnt);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] g, d;
        int tg, td;
        do_reset();
        xi_v[0] = 40'd100; yi_v[0] = 40'd0; ang_v[0] = 32'h1000;
        @(negedge pclk);
        req = 4'b0001;
        wait_gnt(5, g, tg);
        req = '0;
        tests_run++;
        if (g !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_gnt: got %b required 0001", g);
        end
        tests_run++;
        if (cord_start !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_start: got start=%b busy=%b required 1", cord_start, busy);
        end
        wait_done(70, d, td);
        tests_run++;
        if (d !== 4'b0001 || td - tg !== 60) begin
            tests_failed++;
            $display("FAIL single_done: got done=%b latency=%0d required 0001 latency 60", d, td - tg);
        end
        tests_run++;
        if (res_cos !== 40'd101 || res_sin !== 40'h1000 || res_id !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_res: got cos=%0d sin=%0h id=%0d required 101 1000 0", res_cos, res_sin, res_id);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] g, d;
        int tg, td, prev;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < N; k++) begin
            xi_v[k]  = {8'($urandom), 32'($urandom)};
            yi_v[k]  = {8'($urandom), 32'($urandom)};
            ang_v[k] = 32'($urandom);
        end
        @(negedge pclk);
        req  = 4'b1111;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(70, g, tg);
            tests_run++;
            if (g !== (4'b0001 << order[i])) begin
                tests_failed++;
                $display("FAIL rot_order_%0d: got %b required %b", i, g, 4'b0001 << order[i]);
            end
            if (i > 0) begin
                tests_run++;
                if (tg - prev !== 61) begin
                    tests_failed++;
                    $display("FAIL rot_spacing_%0d: got %0d required 61", i, tg - prev);
                end
            end
            prev = tg;
        end
        req = '0;
        wait_done(70, d, td);
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_priority();
        logic [N-1:0] g, d;
        int tg, td;
        logic [N-1:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        do_reset();
        @(negedge pclk);
        req = 4'b0010;
        wait_gnt(5, g, tg);
        req = '0;
        wait_done(70, d, td);
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(70, g, tg);
            tests_run++;
            if (g !== exp_g[i]) begin
                tests_failed++;
                $display("FAIL prio_order_%0d: got %b required %b", i, g, exp_g[i]);
            end
            req = req & ~g;
            if (i == 0 || i == 1) begin
                repeat (10) @(negedge pclk);
                if (i == 0) req[3] = 1'b1;
                else        req[0] = 1'b1;
            end
        end
        req = '0;
        wait_done(70, d, td);
    endtask

    task automatic test_drop();
        logic [N-1:0] g, d;
        int tg, td, extra;
        do_reset();
        xi_v[1] = 40'h12_3456_789A; ang_v[1] = 32'h8000_0001;
        @(negedge pclk);
        req = 4'b0010;
        wait_gnt(5, g, tg);
        repeat (5) @(negedge pclk);
        req = '0;
        wait_done(70, d, td);
        tests_run++;
        if (d !== 4'b0010 || td - tg !== 60) begin
            tests_failed++;
            $display("FAIL drop_done: got done=%b latency=%0d required 0010 latency 60", d, td - tg);
        end
        extra = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge pclk);
            if (gnt != '0) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("FAIL drop_regrant: got %0d grants required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, d;
        int tg, td;
        do_reset();
        xi_v[2] = 40'd7777; ang_v[2] = 32'h0000_4321;
        @(negedge pclk);
        req = 4'b0100;
        wait_gnt(5, g, tg);
        repeat (20) @(posedge pclk);
        #2;
        preset_n = 1'b0;
        sb.delete();
        #1;
        tests_run++;
        if ({cord_start, busy, gnt, done} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got start=%b busy=%b gnt=%b done=%b required 0", cord_start, busy, gnt, done);
        end
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        wait_gnt(3, g, tg);
        req = '0;
        tests_run++;
        if (g !== 4'b0100) begin
            tests_failed++;
            $display("FAIL midreset_regrant: got %b required 0100", g);
        end
        wait_done(70, d, td);
    endtask

    task automatic test_operand_change();
        logic [N-1:0] g, d;
        int tg, td;
        do_reset();
        xi_v[0] = 40'd555; yi_v[0] = 40'd7; ang_v[0] = 32'hFFFF_ABCD;
        xi_v[1] = 40'd42;  yi_v[1] = 40'd3; ang_v[1] = 32'h0000_0777;
        @(negedge pclk);
        req = 4'b0011;
        wait_gnt(5, g, tg);
        req = 4'b0010;
        @(posedge pclk);
        #1;
        xi_v[0] = 40'd999; yi_v[0] = 40'd1; ang_v[0] = 32'h0000_0001;
        @(negedge pclk);
        tests_run++;
        if (cord_xi !== 40'd555 || cord_yi !== 40'd7 || cord_angle !== 32'hFFFF_ABCD) begin
            tests_failed++;
            $display("FAIL chg_latched: got xi=%0d yi=%0d angle=%0h required 555 7 ffffabcd", cord_xi, cord_yi, cord_angle);
        end
        wait_done(70, d, td);
        tests_run++;
        if (d !== 4'b0001 || res_cos !== 40'd556 || res_sin !== 40'hFF_FFFF_ABCD) begin
            tests_failed++;
            $display("FAIL chg_result: got done=%b cos=%0d sin=%0h required 0001 556 ffffffabcd", d, res_cos, res_sin);
        end
        tests_run++;
        if (cord_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL chg_start_gap: got %b required 0", cord_start);
        end
        wait_gnt(5, g, tg);
        req = '0;
        tests_run++;
        if (g !== 4'b0010) begin
            tests_failed++;
            $display("FAIL chg_b2b_gnt: got %b required 0010", g);
        end
        wait_done(70, d, td);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            xi_v[k]  = '0;
            yi_v[k]  = '0;
            ang_v[k] = '0;
        end
        test_reset();
        test_single();
        test_rotation();
        test_priority();
        test_drop();
        test_reset_mid();
        test_operand_change();
        repeat (3) @(negedge pclk);
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
